// File: rtl/shf_meta_buf.sv
// Per-lane metadata queue for the shuffle module.
// Holds up to DEPTH opaque metadata entries, each tagged with its beat count
// minus one, presents the head entry to the shuffle datapath and tracks the
// beat index inside the head request. The head retires on its final beat.
//
// Ports:
//   clk_i, rst_i         clock; asynchronous active-high reset
//   meta_valid_i/ready_o upstream entry handshake
//   meta_i, meta_nb_m1_i entry payload and beats-minus-one
//   cur_valid_o          head entry valid
//   cur_meta_o           head entry payload
//   cur_beat_o           beat index within the head request
//   cur_last_o           head is on its final beat
//   beat_done_i          datapath finished the current beat
//   cnt_o                number of stored entries
//
// Optional feature: define SHF_META_BUF_BYPASS_EN to let an entry pushed into
// an empty buffer appear on cur_* in the same cycle (and be consumed without
// being stored if it is single-beat and retired immediately).
module shf_meta_buf #(
  parameter type         meta_glb_t = logic,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned BEAT_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       meta_valid_i,
  output logic                       meta_ready_o,
  input  meta_glb_t                  meta_i,
  input  logic [BEAT_W-1:0]          meta_nb_m1_i,
  output logic                       cur_valid_o,
  output meta_glb_t                  cur_meta_o,
  output logic [BEAT_W-1:0]          cur_beat_o,
  output logic                       cur_last_o,
  input  logic                       beat_done_i,
  output logic [$clog2(DEPTH):0]     cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  meta_glb_t         r_meta_mem [DEPTH];
  logic [BEAT_W-1:0] r_nb_mem   [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [BEAT_W-1:0] r_beat;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_adv;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [BEAT_W-1:0] w_head_nb;

  // Extra pointer MSB distinguishes full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head_nb = r_nb_mem[r_rd_ptr[AW-1:0]];

  assign meta_ready_o = !w_full;
  assign w_push       = meta_valid_i && !w_full;
  assign cnt_o        = r_wr_ptr - r_rd_ptr;
  assign cur_beat_o   = r_beat;

  // Beat events only count while a head is presented.
  assign w_pop = beat_done_i && cur_valid_o && cur_last_o;
  assign w_adv = beat_done_i && cur_valid_o && !cur_last_o;

`ifdef SHF_META_BUF_BYPASS_EN
  logic w_byp;
  logic w_byp_pop;

  // Empty buffer with an incoming entry: present the input directly.
  assign w_byp       = w_empty && meta_valid_i;
  assign cur_valid_o = !w_empty || meta_valid_i;
  assign cur_meta_o  = w_byp ? meta_i : r_meta_mem[r_rd_ptr[AW-1:0]];
  assign cur_last_o  = w_byp ? (meta_nb_m1_i == BEAT_W'(0))
                             : (!w_empty && (r_beat == w_head_nb));
  // A single-beat bypassed entry retired this cycle is never stored.
  assign w_byp_pop   = w_byp && w_pop;
  assign w_wr_en     = w_push && !w_byp_pop;
  assign w_rd_en     = w_pop && !w_byp;
`else
  assign cur_valid_o = !w_empty;
  assign cur_meta_o  = r_meta_mem[r_rd_ptr[AW-1:0]];
  assign cur_last_o  = !w_empty && (r_beat == w_head_nb);
  assign w_wr_en     = w_push;
  assign w_rd_en     = w_pop;
`endif

  // Pointer and beat-index state; reset discards all queued work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_beat   <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_pop)      r_beat <= '0;
      else if (w_adv) r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_meta_mem[r_wr_ptr[AW-1:0]] <= meta_i;
      r_nb_mem[r_wr_ptr[AW-1:0]]   <= meta_nb_m1_i;
    end
  end

endmodule

// File: tb/tb_shf_meta_buf.sv
module tb_shf_meta_buf;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned MW     = 16;

  typedef logic [MW-1:0] meta_t;
  typedef struct {
    logic [MW-1:0]     m;
    logic [BEAT_W-1:0] nb;
  } ent_t;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              meta_valid_i;
  logic              meta_ready_o;
  meta_t             meta_i;
  logic [BEAT_W-1:0] meta_nb_m1_i;
  logic              cur_valid_o;
  meta_t             cur_meta_o;
  logic [BEAT_W-1:0] cur_beat_o;
  logic              cur_last_o;
  logic              beat_done_i;
  logic [$clog2(DEPTH):0] cnt_o;

  int total = 0;
  int bad   = 0;

  ent_t q[$];
  int   beat = 0;

  shf_meta_buf #(
    .meta_glb_t (meta_t),
    .DEPTH      (DEPTH),
    .BEAT_W     (BEAT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .meta_valid_i (meta_valid_i),
    .meta_ready_o (meta_ready_o),
    .meta_i       (meta_i),
    .meta_nb_m1_i (meta_nb_m1_i),
    .cur_valid_o  (cur_valid_o),
    .cur_meta_o   (cur_meta_o),
    .cur_beat_o   (cur_beat_o),
    .cur_last_o   (cur_last_o),
    .beat_done_i  (beat_done_i),
    .cnt_o        (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic check_all(input string tag);
    logic hv;
    hv = (q.size() > 0);
    chk({tag, "_cnt"},   32'(cnt_o),        32'(q.size()));
    chk({tag, "_ready"}, 32'(meta_ready_o), 32'(q.size() < DEPTH));
    chk({tag, "_valid"}, 32'(cur_valid_o),  32'(hv));
    chk({tag, "_beat"},  32'(cur_beat_o),   32'(beat));
    chk({tag, "_last"},  32'(cur_last_o),   32'(hv && (beat == int'(q[0].nb))));
    if (hv) chk({tag, "_meta"}, 32'(cur_meta_o), 32'(q[0].m));
  endtask

  // One clock cycle: drive inputs, check, advance model at the edge.
  task automatic step(input string tag, input logic v, input logic [MW-1:0] m,
                      input logic [BEAT_W-1:0] nb, input logic d);
    logic do_push, do_pop, do_adv;
    ent_t e;
    meta_valid_i = v;
    meta_i       = m;
    meta_nb_m1_i = nb;
    beat_done_i  = d;
    #1;
    check_all(tag);
    do_push = v && (q.size() < DEPTH);
    do_pop  = d && (q.size() > 0) && (beat == int'(q[0].nb));
    do_adv  = d && (q.size() > 0) && (beat != int'(q[0].nb));
    @(posedge clk_i);
    if (do_pop) begin
      void'(q.pop_front());
      beat = 0;
    end else if (do_adv) begin
      beat++;
    end
    if (do_push) begin
      e.m  = m;
      e.nb = nb;
      q.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    meta_valid_i = 1'b0;
    beat_done_i  = 1'b0;
    rst_i        = 1'b1;
    q.delete();
    beat = 0;
    #1;
    check_all(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    logic              v, d;
    logic [BEAT_W-1:0] nb;
    rst_i        = 1'b1;
    meta_valid_i = 1'b0;
    meta_i       = '0;
    meta_nb_m1_i = '0;
    beat_done_i  = 1'b0;
    #1;
    check_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Three-beat request walks beats 0,1,2 then retires.
    step("a_push", 1'b1, 16'hA000, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) step("a_beat", 1'b0, '0, '0, 1'b1);
    step("a_idle", 1'b0, '0, '0, 1'b0);

    // Fill to DEPTH, then a fifth valid is held off.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 16'hB000 + 16'(i), 8'd0, 1'b0);
    chk("full_ready", 32'(meta_ready_o), 32'd0);
    chk("full_cnt",   32'(cnt_o),        32'd4);
    step("held", 1'b1, 16'hDEAD, 8'd0, 1'b0);
    // Retire head while full: no write in that cycle.
    step("full_pop", 1'b1, 16'hC001, 8'd0, 1'b1);
    chk("after_pop_cnt", 32'(cnt_o), 32'd3);
    step("refill", 1'b1, 16'hC001, 8'd0, 1'b0);
    chk("refill_cnt", 32'(cnt_o), 32'd4);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, '0, 1'b1);

    // Ten single-beat entries streaming: pointers wrap.
    for (int i = 0; i < 10; i++) step("stream", 1'b1, 16'hE000 + 16'(i), 8'd0, 1'b1);
    for (int i = 0; i < 2; i++)  step("stream_drain", 1'b0, '0, '0, 1'b1);

    // beat_done while empty is ignored.
    step("empty_done", 1'b0, '0, '0, 1'b1);
    step("empty_done", 1'b0, '0, '0, 1'b1);
    chk("empty_cnt",  32'(cnt_o),      32'd0);
    chk("empty_beat", 32'(cur_beat_o), 32'd0);

    // Reset in the middle of a request with entries queued.
    step("mr_push", 1'b1, 16'hF000, 8'd3, 1'b0);
    step("mr_push", 1'b1, 16'hF001, 8'd1, 1'b0);
    step("mr_push", 1'b1, 16'hF002, 8'd0, 1'b1);
    chk("mr_beat1", 32'(cur_beat_o), 32'd1);
    do_reset("mid_reset");
    step("post_reset", 1'b0, '0, '0, 1'b0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 2000; n++) begin
      v  = ($urandom_range(0, 99) < 55);
      d  = ($urandom_range(0, 99) < 50);
      nb = ($urandom_range(0, 3) == 0) ? BEAT_W'($urandom_range(1, 5)) : '0;
      if ($urandom_range(0, 399) == 0) do_reset("rnd_reset");
      else step("rnd", v, MW'($urandom), nb, d);
    end
    for (int i = 0; i < 40; i++) step("final_drain", 1'b0, '0, '0, 1'b1);
    chk("final_cnt", 32'(cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
